// File: rtl/uart_tx_pkg.sv
// Shared definitions for the monitor UART transmitter: FSM state encoding,
// character tag constants and the word-to-character split.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Tag 2'b00 is never transmitted; the host uses its absence to resync.
  localparam logic [1:0] TAG_BYTE0 = 2'b01;
  localparam logic [1:0] TAG_BYTE1 = 2'b10;
  localparam logic [1:0] TAG_BYTE2 = 2'b11;

  localparam int BITS_PER_CHAR = 8;

  // Select one tagged character out of the 18-bit held word.
  function automatic logic [7:0] char_of(input logic [17:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return {TAG_BYTE0, w[17:12]};
      2'd1:    return {TAG_BYTE1, w[11:6]};
      default: return {TAG_BYTE2, w[5:0]};
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: 16-bit counter running 0..BAUD_DIV-1 with a single-cycle
// tick on the last count. i_clr restarts the period from 0.
module uart_baud_gen #(
  parameter int BAUD_DIV = 434
) (
  input  logic clk,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

  logic [15:0] r_cnt;

  // Count up, wrapping to 0 at each bit boundary or on clear.
  always_ff @(posedge clk) begin
    if (i_clr || (r_cnt == LAST)) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// Monitor word transmitter: captures one 18-bit word per uart_req/uart_ack
// handshake and sends it as three tagged characters in back-to-back async
// frames on txd. Define UART_TX_PARITY_EN to add an even-parity bit to each
// character (8E1); the default build is 8N1.
//
// Handshake: upstream holds uart_req high with uart_dat stable until it sees
// uart_req & uart_ack; uart_ack is a one-cycle pulse issued only from IDLE,
// and the word is captured on that same edge.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_req,
  output logic        uart_ack,
  input  logic [17:0] uart_dat,
  output logic        txd,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  state_t      r_state;
  logic [17:0] r_hold;
  logic [1:0]  r_idx;
  logic [2:0]  r_bit;
  logic        r_txd;
  logic        r_ack;
  logic        r_busy;

  logic        w_tick;
  logic        w_clr;
  logic [7:0]  w_char;

  // Keep the bit timer parked at 0 while idle so the start bit is full width.
  assign w_clr  = rst || (r_state == ST_IDLE);
  assign w_char = char_of(r_hold, r_idx);

  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk    (clk),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Frame sequencer with registered txd/ack/busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= 18'd0;
      r_idx   <= 2'd0;
      r_bit   <= 3'd0;
      r_txd   <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (uart_req) begin
            r_hold  <= uart_dat;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
            r_idx   <= 2'd0;
            r_txd   <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_bit   <= 3'd0;
            r_txd   <= w_char[0];
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit == 3'(BITS_PER_CHAR - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_txd   <= ^w_char;
              r_state <= ST_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
              r_txd <= w_char[r_bit + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_txd   <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_idx < 2'd2) begin
              r_idx   <= r_idx + 2'd1;
              r_txd   <= 1'b0;
              r_state <= ST_START;
            end else begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd       = r_txd;
  assign uart_ack  = r_ack;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: table vectors, randomized words against a
// behavioural frame model, mid-frame reset and a BAUD_DIV=2 instance.
module tb_uart_tx_frame;
  import uart_tx_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = 10 + PAR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [17:0] dat = 18'd0;
  logic        sel = 1'b0;   // 0: BAUD_DIV=4 instance, 1: BAUD_DIV=2 instance
  int          bd  = 4;

  logic       req_a, req_b, ack_a, ack_b, txd_a, txd_b, busy_a, busy_b;
  logic [2:0] st_a, st_b;
  logic       ack, txdo, busyo;
  logic [2:0] st;

  assign req_a = req & ~sel;
  assign req_b = req & sel;
  assign ack   = sel ? ack_b  : ack_a;
  assign txdo  = sel ? txd_b  : txd_a;
  assign busyo = sel ? busy_b : busy_a;
  assign st    = sel ? st_b   : st_a;

  uart_tx_frame #(.BAUD_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .uart_req(req_a), .uart_ack(ack_a), .uart_dat(dat),
    .txd(txd_a), .busy(busy_a), .dbg_state(st_a)
  );

  uart_tx_frame #(.BAUD_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .uart_req(req_b), .uart_ack(ack_b), .uart_dat(dat),
    .txd(txd_b), .busy(busy_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the three tagged characters of a word.
  function automatic logic [23:0] model_bytes(input logic [17:0] w);
    int b0, b1, b2;
    b0 = 64  + ((int'(w) / 4096) % 64);
    b1 = 128 + ((int'(w) / 64) % 64);
    b2 = 192 + (int'(w) % 64);
    return {8'(b0), 8'(b1), 8'(b2)};
  endfunction

  // Expected line levels, one entry per bit period.
  task automatic build_bits(input logic [23:0] bytes);
    logic [7:0] c;
    int ones;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      c = bytes[23 - 8*k -: 8];
      exp_q.push_back(1'b0);
      ones = 0;
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(c[b]);
        ones += int'(c[b]);
      end
      if (PAR == 1) exp_q.push_back(1'((ones % 2) == 1));
      exp_q.push_back(1'b1);
    end
  endtask

  // ---------------- drivers ----------------
  // Raise req with a word and wait for the ack; drop req once acked.
  task automatic start_word(input logic [17:0] w);
    int lat;
    req = 1'b1;
    dat = w;
    lat = 0;
    while (!ack && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", lat, 1);
    req = 1'b0;
  endtask

  // Check a whole word on the line, starting at the ack sample.
  task automatic observe(input logic [23:0] bytes, input bit toggle,
                         input bit queue_next, input logic [17:0] nw);
    int  nb, cyc, busy_cnt, extra_ack, bad;
    bit  queued;
    build_bits(bytes);
    nb = exp_q.size();
    cyc = 0; busy_cnt = 0; extra_ack = 0; queued = 0;
    for (int bi = 0; bi < nb; bi++) begin
      bad = 0;
      for (int c = 0; c < bd; c++) begin
        if (cyc != 0) @(negedge clk);
        if (txdo !== exp_q[bi]) bad++;
        if (busyo === 1'b1) busy_cnt++;
        if (cyc != 0 && ack !== 1'b0) extra_ack++;
        if (queue_next && cyc == 6) begin
          req = 1'b1;
          dat = nw;
          queued = 1;
        end else if (toggle && !queued) begin
          dat = 18'($urandom);
        end
        cyc++;
      end
      if (bad != 0)
        chk($sformatf("bit%0d_level(bad_cycles)", bi), bad, 0);
      else
        chk($sformatf("bit%0d_level", bi), int'(txdo), int'(exp_q[bi]));
    end
    chk("extra_ack", extra_ack, 0);
    chk("busy_cycles", busy_cnt, nb * bd);
    @(negedge clk);
    chk("busy_after", int'(busyo), 0);
    chk("txd_after", int'(txdo), 1);
    chk("ack_after", int'(ack), 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [17:0] w;
    logic [23:0] bytes;
  } vec_t;

  vec_t tbl[4];

  initial begin
    logic [17:0] w, w2;
    logic [23:0] b;
    int k;

    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] w, w2;
    logic [23:0] b;
    int k;

    tbl[0] = '{18'h2A5C3, 24'h6A97C3};
    tbl[1] = '{18'h00000, 24'h4080C0};
    tbl[2] = '{18'h3FFFF, 24'h7FBFFF};
    tbl[3] = '{18'h12345, 24'h528DC5};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", int'(txdo), 1);
    chk("rst_busy", int'(busyo), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_state", int'(st), int'(ST_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_txd", int'(txdo), 1);

    // Table vectors; each next request is raised mid-frame and must wait.
    for (int i = 0; i < 4; i++) begin
      start_word(tbl[i].w);
      observe(tbl[i].bytes, 1'b0, (i < 3), (i < 3) ? tbl[i + 1].w : 18'd0);
    end
    repeat (3) @(negedge clk);

    // Random words with uart_dat scrambled during the frame.
    for (int i = 0; i < 5; i++) begin
      w = 18'($urandom);
      start_word(w);
      observe(model_bytes(w), 1'b1, 1'b0, 18'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during DATA bit 3 of byte1, then a fresh word from byte0.
    w = 18'($urandom);
    w2 = 18'($urandom);
    b = model_bytes(w);
    start_word(w);
    k = FL * bd + 4 * bd + 1;
    repeat (k) @(negedge clk);
    chk("pre_rst_txd", int'(txdo), int'(b[11]));
    chk("pre_rst_busy", int'(busyo), 1);
    rst = 1'b1;
    req = 1'b1;
    dat = w2;
    @(negedge clk);
    chk("mid_rst_txd", int'(txdo), 1);
    chk("mid_rst_busy", int'(busyo), 0);
    chk("mid_rst_state", int'(st), int'(ST_IDLE));
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_ack", int'(ack), 0);
    end
    rst = 1'b0;
    start_word(w2);
    observe(model_bytes(w2), 1'b0, 1'b0, 18'd0);
    repeat (3) @(negedge clk);

    // BAUD_DIV=2 boundary instance.
    sel = 1'b1;
    bd = 2;
    @(negedge clk);
    start_word(tbl[0].w);
    observe(tbl[0].bytes, 1'b0, 1'b0, 18'd0);
    w = 18'($urandom);
    start_word(w);
    observe(model_bytes(w), 1'b1, 1'b0, 18'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
